// File: rtl/core_timer_multi_if.sv
// MMIO bus bundle for the machine timer.
// Handshake: the master presents mmio_req with wen/addr/wdata for one cycle.
// The slave always grants (mmio_gnt=1). mmio_rdata and mmio_error are valid
// from the rising edge that follows the request cycle and hold until the
// next request.
interface core_timer_multi_if;
    logic        mmio_req;
    logic        mmio_wen;
    logic [38:0] mmio_addr;
    logic [63:0] mmio_wdata;
    logic        mmio_gnt;
    logic [63:0] mmio_rdata;
    logic        mmio_error;

    modport master (
        output mmio_req, mmio_wen, mmio_addr, mmio_wdata,
        input  mmio_gnt, mmio_rdata, mmio_error
    );

    modport slave (
        input  mmio_req, mmio_wen, mmio_addr, mmio_wdata,
        output mmio_gnt, mmio_rdata, mmio_error
    );
endinterface

// File: rtl/core_timer_multi.sv
// Machine timer: 64-bit mtime with a prescaler and NCMP mtimecmp channels,
// each with a registered interrupt line. Register window on the MMIO bus:
// 0x00 MTIME, 0x08 PRESCALE, 0x10+8*i MTIMECMP[i].
module core_timer_multi #(
    parameter logic [38:0] MMIO_BASE      = 39'd0,
    parameter int          NCMP           = 2,
    parameter int          PRESCALE_W     = 8,
    parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                 g_clk,
    input  logic                 g_resetn,
    input  logic                 inhibit_tm,
    core_timer_multi_if.slave    mmio,
    output logic [63:0]          ctr_time,
    output logic [NCMP-1:0]      timer_interrupt
);

    localparam logic [38:0] WIN_END = 39'(16 + 8 * NCMP);

    logic [63:0]           mtime_q, mtime_d;
    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [63:0]           mtimecmp_q [NCMP];
    logic [63:0]           mtimecmp_d [NCMP];
    logic [NCMP-1:0]       irq_q, irq_d;
    logic [63:0]           rdata_q, rdata_d;
    logic                  error_q, error_d;

    logic [38:0]     offset;
    logic            legal;
    logic [3:0]      idx;
    logic            wr_legal;
    logic            wr_mtime;
    logic            wr_pre;
    logic            rollover;
    logic [63:0]     reg_val;

    // Address decode and read mux of the pre-update register values.
    always_comb begin
        offset   = mmio.mmio_addr - MMIO_BASE;
        legal    = (mmio.mmio_addr[2:0] == 3'b000) &&
                   (mmio.mmio_addr >= MMIO_BASE) && (offset < WIN_END);
        idx      = offset[6:3];
        wr_legal = mmio.mmio_req && mmio.mmio_wen && legal;
        wr_mtime = wr_legal && (idx == 4'd0);
        wr_pre   = wr_legal && (idx == 4'd1);
        reg_val  = '0;
        if (idx == 4'd0) reg_val = mtime_q;
        if (idx == 4'd1) reg_val = 64'(prescale_q);
        for (int i = 0; i < NCMP; i++) begin
            if (idx == 4'(i + 2)) reg_val = mtimecmp_q[i];
        end
    end

    // Next-state: prescaler, mtime (write beats increment), compare regs,
    // interrupt lines and the registered bus response.
    always_comb begin
        rollover   = !inhibit_tm && (pre_cnt_q == prescale_q);
        mtime_d    = mtime_q;
        pre_cnt_d  = pre_cnt_q;
        prescale_d = prescale_q;
        rdata_d    = rdata_q;
        error_d    = error_q;

        if (!inhibit_tm) begin
            pre_cnt_d = rollover ? '0 : pre_cnt_q + 1'b1;
        end
        if (wr_mtime) begin
            mtime_d   = mmio.mmio_wdata;
            pre_cnt_d = '0;
        end else if (rollover) begin
            mtime_d = mtime_q + 64'd1;
        end
        if (wr_pre) begin
            // The rollover above already used the old prescale value.
            prescale_d = mmio.mmio_wdata[PRESCALE_W-1:0];
            pre_cnt_d  = '0;
        end

        for (int i = 0; i < NCMP; i++) begin
            mtimecmp_d[i] = mtimecmp_q[i];
            if (wr_legal && (idx == 4'(i + 2))) mtimecmp_d[i] = mmio.mmio_wdata;
            irq_d[i] = (mtime_q >= mtimecmp_q[i]);
        end

        if (mmio.mmio_req) begin
            error_d = !legal;
            if (!mmio.mmio_wen) rdata_d = legal ? reg_val : 64'd0;
        end
    end

    // State registers, cleared asynchronously by g_resetn.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            mtime_q    <= '0;
            pre_cnt_q  <= '0;
            prescale_q <= '0;
            irq_q      <= '0;
            rdata_q    <= '0;
            error_q    <= 1'b0;
            for (int i = 0; i < NCMP; i++) mtimecmp_q[i] <= MTIMECMP_RESET;
        end else begin
            mtime_q    <= mtime_d;
            pre_cnt_q  <= pre_cnt_d;
            prescale_q <= prescale_d;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
            error_q    <= error_d;
            for (int i = 0; i < NCMP; i++) mtimecmp_q[i] <= mtimecmp_d[i];
        end
    end

    assign ctr_time        = mtime_q;
    assign timer_interrupt = irq_q;
    assign mmio.mmio_gnt   = 1'b1;
    assign mmio.mmio_rdata = rdata_q;
    assign mmio.mmio_error = error_q;

endmodule
